// File: rtl/msg_display_queue.sv
// Message display queue: buffers EMIT_MSG outputs tagged with PID and
// shows them one at a time for a fixed hold time with a blank gap.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   msg_sign   - push request, sampled every cycle
//   msg_code   - message code to queue
//   msg_pid    - PID tag to queue with the code
//   skip       - ends the current SHOW early
//   disp_msg   - message code being shown
//   disp_pid   - PID tag being shown
//   disp_valid - high while a message is shown
//   fifo_count - entries queued, excluding the one shown
//   fifo_full  - fifo_count == DEPTH
//   overflow   - sticky, a push was dropped
module msg_display_queue #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     msg_sign,
  input  logic [4:0]               msg_code,
  input  logic [4:0]               msg_pid,
  input  logic                     skip,
  output logic [4:0]               disp_msg,
  output logic [4:0]               disp_pid,
  output logic                     disp_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [9:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;

  logic [HW-1:0]   r_hold;
  logic [GW-1:0]   r_gap;
  logic [4:0]      r_disp_msg;
  logic [4:0]      r_disp_pid;
  logic            r_disp_valid;

  logic            w_nonempty;
  logic            w_full;
  logic            w_pop;
  logic            w_end;
  logic            w_push;
  logic            w_drop;

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CW'(DEPTH));

  // A pop frees a slot on the same edge, so a push at full
  // is only dropped when no pop happens.
  assign w_push = msg_sign && (!w_full || w_pop);
  assign w_drop = msg_sign && w_full && !w_pop;

  // FIFO storage and bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {msg_pid, msg_code};
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // State register and display datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_gap        <= '0;
      r_disp_msg   <= '0;
      r_disp_pid   <= '0;
      r_disp_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        {r_disp_pid, r_disp_msg} <= r_mem[r_rptr];
        r_disp_valid <= 1'b1;
        r_hold       <= HW'(HOLD_CYCLES - 1);
      end else if (w_end) begin
        r_disp_msg   <= '0;
        r_disp_pid   <= '0;
        r_disp_valid <= 1'b0;
        r_gap        <= GW'(GAP_CYCLES - 1);
      end else if (r_state == S_SHOW) begin
        r_hold <= r_hold - 1'b1;
      end else if (r_state == S_GAP && r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_nonempty) w_next = S_SHOW;
      end
      S_SHOW: begin
        if (w_end) w_next = S_GAP;
      end
      S_GAP: begin
        if (r_gap == '0) begin
          w_next = w_nonempty ? S_SHOW : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Control outputs: pop only sees entries present before the edge
  always_comb begin
    w_pop = 1'b0;
    w_end = 1'b0;
    unique case (r_state)
      S_IDLE: w_pop = w_nonempty;
      S_SHOW: w_end = (r_hold == '0) || skip;
      S_GAP:  w_pop = (r_gap == '0) && w_nonempty;
      default: begin
        w_pop = 1'b0;
        w_end = 1'b0;
      end
    endcase
  end

  assign disp_msg   = r_disp_msg;
  assign disp_pid   = r_disp_pid;
  assign disp_valid = r_disp_valid;
  assign fifo_count = r_count;
  assign fifo_full  = w_full;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_msg_display_queue.sv
// Testbench for msg_display_queue: scoreboard of queued messages
// checked as they appear on the display, plus per-scenario checks.
module tb_msg_display_queue;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       msg_sign = 1'b0;
  logic [4:0] msg_code = '0;
  logic [4:0] msg_pid = '0;
  logic       skip = 1'b0;
  logic [4:0] disp_msg;
  logic [4:0] disp_pid;
  logic       disp_valid;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       overflow;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] sb[$];
  int         exp_len = HOLD;
  logic       prev_v = 1'b0;
  int         run = 0;

  msg_display_queue #(
    .DEPTH(DEPTH),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .msg_sign(msg_sign),
    .msg_code(msg_code),
    .msg_pid(msg_pid),
    .skip(skip),
    .disp_msg(disp_msg),
    .disp_pid(disp_pid),
    .disp_valid(disp_valid),
    .fifo_count(fifo_count),
    .fifo_full(fifo_full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Display monitor: content against scoreboard, length against exp_len
  always @(negedge clk) begin
    if (!reset) begin
      prev_v = 1'b0;
      run = 0;
    end else begin
      if (disp_valid && !prev_v) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL mon_unexpected: got %h/%h want none",
                   disp_pid, disp_msg);
        end else begin
          logic [9:0] e;
          e = sb.pop_front();
          if ({disp_pid, disp_msg} !== e) begin
            n_bad++;
            $display("FAIL mon_content: got %h/%h want %h/%h",
                     disp_pid, disp_msg, e[9:5], e[4:0]);
          end
        end
        run = 1;
      end else if (disp_valid) begin
        run++;
      end
      if (!disp_valid && prev_v) begin
        n_cmp++;
        if (run !== exp_len) begin
          n_bad++;
          $display("FAIL mon_hold_len: got %0d want %0d", run, exp_len);
        end
      end
      prev_v = disp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] c, input logic [4:0] p,
                      input bit ok);
    msg_sign = 1'b1;
    msg_code = c;
    msg_pid  = p;
    if (ok) sb.push_back({p, c});
    tick();
  endtask

  task automatic do_reset();
    msg_sign = 1'b0;
    skip = 1'b0;
    reset = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string tag);
    int i;
    i = 0;
    while ((sb.size() != 0 || disp_valid) && i < 200) begin
      tick();
      i++;
    end
    n_cmp++;
    if (i >= 200) begin
      n_bad++;
      $display("FAIL %s_drain: timeout, %0d left want 0", tag, sb.size());
    end
    repeat (GAP + 1) tick();
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b0;
    #2;
    n_cmp++;
    if (disp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid: got %b want 0", disp_valid);
    end
    n_cmp++;
    if (disp_msg !== 5'd0) begin
      n_bad++; $display("FAIL rst_msg: got %h want 0", disp_msg);
    end
    n_cmp++;
    if (disp_pid !== 5'd0) begin
      n_bad++; $display("FAIL rst_pid: got %h want 0", disp_pid);
    end
    n_cmp++;
    if (fifo_count !== 3'd0) begin
      n_bad++; $display("FAIL rst_count: got %0d want 0", fifo_count);
    end
    n_cmp++;
    if (fifo_full !== 1'b0) begin
      n_bad++; $display("FAIL rst_full: got %b want 0", fifo_full);
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL rst_ovf: got %b want 0", overflow);
    end
    do_reset();
  endtask

  task automatic test_single();
    int len;
    send(5'h03, 5'h02, 1'b1);
    msg_sign = 1'b0;
    n_cmp++;
    if (fifo_count !== 3'd1) begin
      n_bad++; $display("FAIL single_cnt1: got %0d want 1", fifo_count);
    end
    n_cmp++;
    if (disp_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_early: got %b want 0", disp_valid);
    end
    tick();
    n_cmp++;
    if (fifo_count !== 3'd0) begin
      n_bad++; $display("FAIL single_cnt0: got %0d want 0", fifo_count);
    end
    n_cmp++;
    if (disp_valid !== 1'b1 || disp_msg !== 5'h03 || disp_pid !== 5'h02)
    begin
      n_bad++;
      $display("FAIL single_show: got %b %h/%h want 1 02/03",
               disp_valid, disp_pid, disp_msg);
    end
    len = 1;
    while (disp_valid && len < 20) begin
      tick();
      if (disp_valid) len++;
    end
    n_cmp++;
    if (len !== HOLD) begin
      n_bad++; $display("FAIL single_len: got %0d want %0d", len, HOLD);
    end
    n_cmp++;
    if (disp_msg !== 5'd0 || disp_pid !== 5'd0 || fifo_count !== 3'd0)
    begin
      n_bad++;
      $display("FAIL single_clear: got %h/%h cnt %0d want 0/0 cnt 0",
               disp_pid, disp_msg, fifo_count);
    end
    repeat (GAP + 3) tick();
    n_cmp++;
    if (disp_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_idle: got %b want 0", disp_valid);
    end
  endtask

  task automatic test_burst();
    int   blank;
    int   gaps;
    bit   fell;
    logic pv;
    for (int i = 1; i <= 3; i++) send(5'(i), 5'h05, 1'b1);
    msg_sign = 1'b0;
    blank = 0;
    gaps = 0;
    fell = 1'b0;
    pv = disp_valid;
    for (int i = 0; i < 80 && gaps < 2; i++) begin
      tick();
      if (!disp_valid) blank++;
      if (disp_valid && !pv && fell) begin
        gaps++;
        n_cmp++;
        if (blank !== GAP) begin
          n_bad++; $display("FAIL burst_gap: got %0d want %0d", blank, GAP);
        end
      end
      if (pv && !disp_valid) fell = 1'b1;
      if (disp_valid) blank = 0;
      pv = disp_valid;
    end
    n_cmp++;
    if (gaps !== 2) begin
      n_bad++; $display("FAIL burst_gaps_seen: got %0d want 2", gaps);
    end
    wait_drain("burst");
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL burst_ovf: got %b want 0", overflow);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      send(5'(16 + i), 5'h01, i < 5);
      if (i == 4) begin
        n_cmp++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
          n_bad++;
          $display("FAIL ovf_prefull: got full %b ovf %b want 1 0",
                   fifo_full, overflow);
        end
      end
    end
    msg_sign = 1'b0;
    n_cmp++;
    if (fifo_count !== 3'd4 || fifo_full !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_full: got cnt %0d full %b want 4 1",
               fifo_count, fifo_full);
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_set: got %b want 1", overflow);
    end
    wait_drain("ovf");
    n_cmp++;
    if (overflow !== 1'b1 || fifo_count !== 3'd0 || fifo_full !== 1'b0)
    begin
      n_bad++;
      $display("FAIL ovf_sticky: got ovf %b cnt %0d full %b want 1 0 0",
               overflow, fifo_count, fifo_full);
    end
  endtask

  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 5; i++) send(5'(17 + i), 5'(i), 1'b1);
    msg_sign = 1'b0;
    n_cmp++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || disp_valid !== 1'b1)
    begin
      n_bad++;
      $display("FAIL simul_fill: got cnt %0d ovf %b v %b want 4 0 1",
               fifo_count, overflow, disp_valid);
    end
    tick();
    n_cmp++;
    if (disp_valid !== 1'b0) begin
      n_bad++; $display("FAIL simul_gap: got %b want 0", disp_valid);
    end
    tick();
    send(5'h1A, 5'h07, 1'b1);
    msg_sign = 1'b0;
    n_cmp++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_pushpop: got cnt %0d ovf %b want 4 0",
               fifo_count, overflow);
    end
    n_cmp++;
    if (disp_valid !== 1'b1 || disp_msg !== 5'h12) begin
      n_bad++;
      $display("FAIL simul_pop: got %b %h want 1 12", disp_valid, disp_msg);
    end
    wait_drain("simul");
  endtask

  task automatic test_skip();
    exp_len = 2;
    send(5'h07, 5'h03, 1'b1);
    send(5'h08, 5'h03, 1'b1);
    msg_sign = 1'b0;
    n_cmp++;
    if (disp_valid !== 1'b1 || disp_msg !== 5'h07) begin
      n_bad++;
      $display("FAIL skip_show: got %b %h want 1 07", disp_valid, disp_msg);
    end
    tick();
    skip = 1'b1;
    tick();
    n_cmp++;
    if (disp_valid !== 1'b0) begin
      n_bad++; $display("FAIL skip_cut: got %b want 0", disp_valid);
    end
    @(negedge clk);
    #1;
    exp_len = HOLD;
    tick();
    n_cmp++;
    if (disp_valid !== 1'b0) begin
      n_bad++; $display("FAIL skip_gap1: got %b want 0", disp_valid);
    end
    tick();
    skip = 1'b0;
    n_cmp++;
    if (disp_valid !== 1'b1 || disp_msg !== 5'h08) begin
      n_bad++;
      $display("FAIL skip_gap_len: got %b %h want 1 08",
               disp_valid, disp_msg);
    end
    wait_drain("skip");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) send(5'(32 + i), 5'h09, i < 2);
    msg_sign = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (disp_valid !== 1'b1 || disp_msg !== 5'h01 ||
        overflow !== 1'b1 || fifo_count !== 3'd3) begin
      n_bad++;
      $display("FAIL arst_pre: got v%b %h ovf %b cnt %0d want 1 01 1 3",
               disp_valid, disp_msg, overflow, fifo_count);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (disp_valid !== 1'b0 || disp_msg !== 5'd0) begin
      n_bad++;
      $display("FAIL arst_disp: got %b %h want 0 00", disp_valid, disp_msg);
    end
    n_cmp++;
    if (fifo_count !== 3'd0 || fifo_full !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_fifo: got cnt %0d full %b want 0 0",
               fifo_count, fifo_full);
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL arst_ovf: got %b want 0", overflow);
    end
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (disp_valid !== 1'b0 || fifo_count !== 3'd0) begin
        n_bad++;
        $display("FAIL arst_idle: got v%b cnt %0d want 0 0",
                 disp_valid, fifo_count);
      end
    end
    send(5'h1F, 5'h04, 1'b1);
    msg_sign = 1'b0;
    tick();
    n_cmp++;
    if (disp_valid !== 1'b1 || disp_msg !== 5'h1F) begin
      n_bad++;
      $display("FAIL arst_resume: got %b %h want 1 1f",
               disp_valid, disp_msg);
    end
    wait_drain("arst");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simul();
    test_skip();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/msg_display_queue.md
Name: msg_display_queue

Overview:
Downstream consumer of the environment-variables stage's message outputs (MSG_OUT, MSG_Sign, PID_out). It queues every message emitted by an EMIT_MSG instruction, tagged with the PID active at emission. It then presents the queued messages one at a time to the board display for a fixed hold time, with a blank gap between messages. An operator skip input can cut the hold short.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >=2
HOLD_CYCLES, 50000000, cycles each message is shown; >=1
GAP_CYCLES, 2, blank cycles after each message; >=1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
msg_sign  in  1  upstream MSG_Sign; push request, sampled every cycle
msg_code  in  5  upstream MSG_OUT
msg_pid  in  5  upstream PID_out at emission
skip  in  1  synchronous; ends the current SHOW early
disp_msg  out  5  message code being shown
disp_pid  out  5  PID tag being shown
disp_valid  out  1  high while a message is shown
fifo_count  out  clog2(DEPTH)+1  entries queued, excluding the one shown
fifo_full  out  1  fifo_count == DEPTH
overflow  out  1  sticky; a push was dropped

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FIFO pointers 0, state IDLE, counters 0. Reset mid-SHOW or mid-GAP aborts immediately and discards the queue.
- Push: every rising edge with msg_sign=1 writes {msg_pid,msg_code} at the write pointer.
  - A multi-cycle msg_sign (back-to-back EMIT instructions) pushes once per cycle.
- Pointers wrap modulo DEPTH. fifo_count = number of written entries not yet popped.
- Full, no pop in the same cycle: push is dropped, overflow is set to 1, and the FIFO is unchanged.
- Full, with a pop in the same cycle: push is accepted and count is unchanged.
- Empty, with a push in the same cycle: the entry cannot be popped that cycle. Pop sees only entries present before the edge.
- overflow clears only on reset.
- FSM states IDLE, SHOW, GAP:
  - IDLE: if fifo_count>0, pop the head into disp_msg/disp_pid, set disp_valid=1, load hold_cnt=HOLD_CYCLES-1, go to SHOW. Otherwise stay in IDLE.
  - SHOW: if hold_cnt==0 or skip==1, clear disp_valid/disp_msg/disp_pid to 0, load gap_cnt=GAP_CYCLES-1, go to GAP. Otherwise decrement hold_cnt.
  - GAP: if gap_cnt!=0, decrement. If gap_cnt==0 and fifo_count>0, pop the next entry directly into SHOW (same actions as IDLE). If gap_cnt==0 and the FIFO is empty, go to IDLE.
  - skip is ignored in IDLE and GAP.
- Timing:
  - An entry pushed into an empty FIFO in IDLE at edge N is displayed (disp_valid=1) after edge N+1.
  - A message is shown for exactly HOLD_CYCLES cycles without skip. With skip it is shown for k+1 cycles, where k is the index of the first SHOW cycle with skip=1.
  - Blank time between consecutive messages is exactly GAP_CYCLES cycles.
- hold_cnt width is clog2(HOLD_CYCLES)+1; no wrap is possible.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
(All scenarios use DEPTH=4, HOLD_CYCLES=4, GAP_CYCLES=2.)
- Single message: reset, then one cycle msg_sign=1, msg_code=0x03, msg_pid=0x02.
  - Required: fifo_count=1 for one cycle; then disp_valid=1, disp_msg=0x03, disp_pid=0x02 for exactly 4 cycles; then all 0, state returns to IDLE, fifo_count=0.
- Burst: msg_sign=1 for 3 cycles with codes 0x01, 0x02, 0x03 (pid 0x05).
  - Required: shown in order, each for 4 cycles, separated by exactly 2 blank cycles; overflow stays 0.
- Overflow: msg_sign=1 for 6 cycles with codes 0x10..0x15.
  - Required: 0x10 is popped to the display; 0x11..0x14 are queued, fifo_full=1; 0x15 is dropped and overflow=1 (sticky).
  - Display sequence is 0x10..0x14.
- Skip: skip=1 on the 2nd SHOW cycle of message 0x07.
  - Required: disp_valid falls after exactly 2 cycles; skip pulses during GAP have no effect.
- Simultaneous push and pop at full: a push on the same edge as a GAP-to-SHOW pop while fifo_count=4.
  - Required: push accepted, fifo_count stays 4, overflow unchanged.
- Async reset: assert reset=0 between clock edges mid-SHOW.
  - Required: disp_valid, fifo_count, overflow go to 0 immediately; after release the block idles until the next msg_sign.
